// File: rtl/cache_pkg.sv
// Shared types for the cache tag engine: command codes, FSM states and the per-line state record.
package cache_pkg;

    // Tag storage width; engine instances zero-extend their real tag into this field.
    localparam int TAG_W_MAX = 64;

    typedef enum logic [3:0] {
        CMD_READ      = 4'd0,
        CMD_WRITE     = 4'd1,
        CMD_IFETCH    = 4'd2,
        CMD_SNOOP_INV = 4'd3,
        CMD_CLEAR     = 4'd8
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE,
        CLEAR
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_W_MAX-1:0] tag;
    } line_t;

    function automatic logic is_access(input logic [3:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE) || (cmd == CMD_IFETCH);
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU for one set: combinational victim walk and the tree value after touching a way.
module cache_plru_tree #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-2:0]         tree,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         tree_touched
);
    localparam int LVL = $clog2(WAYS);

    // Heap layout: node n has children 2n+1 / 2n+2; a 0 bit points the victim walk left.
    always_comb begin
        int node;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            node = 2 * node + 1 + int'(tree[node]);
        end
        victim = LVL'(node - (WAYS - 1));
    end

    always_comb begin
        int  node;
        logic dir;
        node         = 0;
        tree_touched = tree;
        for (int l = 0; l < LVL; l++) begin
            dir                = touch_way[LVL-1-l];
            tree_touched[node] = ~dir;
            node               = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/cache_tag_engine.sv
// Set-associative tag/state engine with tree PLRU replacement and saturating statistics.
// Define CACHE_EVICT_STATS_EN to enable the evict_cntr/wb_cntr counters (tied to 0 otherwise).
//
// state  | meaning
// IDLE   | req_ready high, waiting for a command
// LOOKUP | indexed set read, all ways compared, victim chosen
// UPDATE | line/PLRU/counter write-back, resp_valid pulse
// CLEAR  | one set invalidated per cycle, SETS cycles
module cache_tag_engine
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 8,
    parameter int LINE_BYTES = 64,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_cmd,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic [CNT_W-1:0]        hit_cntr,
    output logic [CNT_W-1:0]        miss_cntr,
    output logic [CNT_W-1:0]        evict_cntr,
    output logic [CNT_W-1:0]        wb_cntr
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    state_e               state, state_nxt;
    logic [3:0]           cmd_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic [IDX_W-1:0]     clr_cnt;
    line_t                lines [SETS][WAYS];
    logic [WAYS-2:0]      plru  [SETS];

    logic                 accept;
    logic                 lk_hit;
    logic [WAY_W-1:0]     lk_way;
    logic [TAG_W_MAX-1:0] tag_ext;
    logic                 hit_c, inv_any_c, vic_valid_c, vic_dirty_c;
    logic [WAY_W-1:0]     hit_way_c, inv_way_c, vic_way_c, plru_vic;
    logic [WAYS-2:0]      plru_touched;
    logic                 unused_offset;

    assign accept        = req_valid & req_ready;
    assign tag_ext       = TAG_W_MAX'(tag_q);
    assign unused_offset = ^req_addr[OFF_W-1:0];

    cache_plru_tree #(.WAYS(WAYS)) u_plru (
        .tree         (plru[idx_q]),
        .touch_way    (lk_way),
        .victim       (plru_vic),
        .tree_touched (plru_touched)
    );

    // Descending scan leaves the lowest-index invalid way in inv_way_c.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_any_c = 1'b0;
        inv_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!lines[idx_q][w].valid) begin
                inv_any_c = 1'b1;
                inv_way_c = WAY_W'(w);
            end
            if (lines[idx_q][w].valid && (lines[idx_q][w].tag == tag_ext)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        vic_way_c   = inv_any_c ? inv_way_c : plru_vic;
        vic_valid_c = lines[idx_q][vic_way_c].valid;
        vic_dirty_c = lines[idx_q][vic_way_c].dirty;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_nxt = (req_cmd == CMD_CLEAR) ? CLEAR : LOOKUP;
            end
            LOOKUP: state_nxt = UPDATE;
            CLEAR:  if (clr_cnt == '0) state_nxt = UPDATE;
            UPDATE: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state    <= IDLE;
            cmd_q    <= '0;
            idx_q    <= '0;
            tag_q    <= '0;
            clr_cnt  <= '0;
            lk_hit   <= 1'b0;
            lk_way   <= '0;
            resp_hit <= 1'b0;
            resp_way <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q   <= req_cmd;
                idx_q   <= req_addr[OFF_W +: IDX_W];
                tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
                clr_cnt <= IDX_W'(SETS - 1);
            end
            if (state == CLEAR) begin
                if (clr_cnt != '0) begin
                    clr_cnt <= clr_cnt - IDX_W'(1);
                end else begin
                    resp_hit <= 1'b0;
                    resp_way <= '0;
                end
            end
            if (state == LOOKUP) begin
                lk_hit <= hit_c;
                if (is_access(cmd_q)) begin
                    lk_way   <= hit_c ? hit_way_c : vic_way_c;
                    resp_hit <= hit_c;
                    resp_way <= hit_c ? hit_way_c : vic_way_c;
                end else if (cmd_q == CMD_SNOOP_INV) begin
                    lk_way   <= hit_way_c;
                    resp_hit <= hit_c;
                    resp_way <= hit_way_c;
                end else begin
                    resp_hit <= 1'b0;
                    resp_way <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            for (int s = 0; s < SETS; s++) begin
                plru[s] <= '0;
                for (int w = 0; w < WAYS; w++) lines[s][w] <= '0;
            end
        end else begin
            if (state == CLEAR) begin
                plru[clr_cnt] <= '0;
                for (int w = 0; w < WAYS; w++) lines[clr_cnt][w] <= '0;
            end
            if (state == UPDATE) begin
                if (is_access(cmd_q)) begin
                    plru[idx_q] <= plru_touched;
                    if (!lk_hit) begin
                        lines[idx_q][lk_way] <= '{valid: 1'b1, dirty: (cmd_q == CMD_WRITE), tag: tag_ext};
                    end else if (cmd_q == CMD_WRITE) begin
                        lines[idx_q][lk_way].dirty <= 1'b1;
                    end
                end else if ((cmd_q == CMD_SNOOP_INV) && lk_hit) begin
                    lines[idx_q][lk_way] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            hit_cntr  <= '0;
            miss_cntr <= '0;
        end else if (state == UPDATE) begin
            if (cmd_q == CMD_CLEAR) begin
                hit_cntr  <= '0;
                miss_cntr <= '0;
            end else if (is_access(cmd_q)) begin
                if (lk_hit) begin
                    if (hit_cntr != '1) hit_cntr <= hit_cntr + CNT_W'(1);
                end else if (miss_cntr != '1) begin
                    miss_cntr <= miss_cntr + CNT_W'(1);
                end
            end
        end
    end

`ifdef CACHE_EVICT_STATS_EN
    logic lk_vic_valid, lk_vic_dirty;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            lk_vic_valid <= 1'b0;
            lk_vic_dirty <= 1'b0;
            evict_cntr   <= '0;
            wb_cntr      <= '0;
        end else begin
            if (state == LOOKUP) begin
                lk_vic_valid <= vic_valid_c;
                lk_vic_dirty <= vic_dirty_c;
            end
            if (state == UPDATE) begin
                if (cmd_q == CMD_CLEAR) begin
                    evict_cntr <= '0;
                    wb_cntr    <= '0;
                end else if (is_access(cmd_q) && !lk_hit && lk_vic_valid) begin
                    if (evict_cntr != '1) evict_cntr <= evict_cntr + CNT_W'(1);
                    if (lk_vic_dirty && (wb_cntr != '1)) wb_cntr <= wb_cntr + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_stats;

    assign unused_stats = vic_valid_c ^ vic_dirty_c;
    assign evict_cntr   = '0;
    assign wb_cntr      = '0;
`endif

endmodule

// File: tb/tb_cache_tag_engine.sv
// Directed plus randomized bench for cache_tag_engine against a timestamp-based pseudo-LRU model.
module tb_cache_tag_engine;
    localparam int SETS = 64;
    localparam int WAYS = 8;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic        resp_valid, resp_hit;
    logic [2:0]  resp_way;
    logic [15:0] hit_cntr, miss_cntr, evict_cntr, wb_cntr;

    int checks = 0;
    int failures = 0;

    // Reference state: valid/dirty/tag per line, last-touch timestamp per line for PLRU.
    bit          mv  [SETS][WAYS];
    bit          md  [SETS][WAYS];
    int unsigned mt  [SETS][WAYS];
    int unsigned mts [SETS][WAYS];
    int unsigned ts_ctr;
    int unsigned m_hit, m_miss, m_evict, m_wb;
    logic        obs_hit;
    logic [2:0]  obs_way;

    cache_tag_engine dut (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_way(resp_way), .hit_cntr(hit_cntr),
        .miss_cntr(miss_cntr), .evict_cntr(evict_cntr), .wb_cntr(wb_cntr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0; md[s][w] = 0; mt[s][w] = 0; mts[s][w] = 0;
            end
        ts_ctr = 0; m_hit = 0; m_miss = 0; m_evict = 0; m_wb = 0;
    endfunction

    // The victim half at each tree level is the one whose most recent touch is older.
    function automatic int plru_victim(input int s);
        int lo, size, half;
        int unsigned ml, mr;
        lo = 0;
        size = WAYS;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < half; i++) begin
                if (mts[s][lo+i] > ml) ml = mts[s][lo+i];
                if (mts[s][lo+half+i] > mr) mr = mts[s][lo+half+i];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    function automatic void sat_inc(inout int unsigned c);
        if (c < 32'hFFFF) c = c + 1;
    endfunction

    function automatic void model_cmd(input logic [3:0] cmd, input logic [31:0] addr,
                                      output logic eh, output logic [2:0] ew);
        int s, hw, v;
        int unsigned t;
        s = int'((addr >> 6) % SETS);
        t = addr >> 12;
        eh = 0;
        ew = 0;
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        if (cmd == 4'd0 || cmd == 4'd1 || cmd == 4'd2) begin
            if (hw >= 0) begin
                eh = 1; ew = 3'(hw);
                sat_inc(m_hit);
                if (cmd == 4'd1) md[s][hw] = 1;
                v = hw;
            end else begin
                sat_inc(m_miss);
                v = -1;
                for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
                if (v < 0) v = plru_victim(s);
                if (mv[s][v]) begin
                    sat_inc(m_evict);
                    if (md[s][v]) sat_inc(m_wb);
                end
                mv[s][v] = 1; md[s][v] = (cmd == 4'd1); mt[s][v] = t;
                ew = 3'(v);
            end
            ts_ctr++;
            mts[s][v] = ts_ctr;
        end else if (cmd == 4'd3) begin
            if (hw >= 0) begin
                eh = 1; ew = 3'(hw);
                mv[s][hw] = 0; md[s][hw] = 0;
            end
        end else if (cmd == 4'd8) begin
            model_reset();
        end
    endfunction

    task automatic check_counters(input string name);
        check({name, "_hit_cntr"}, 32'(hit_cntr), m_hit);
        check({name, "_miss_cntr"}, 32'(miss_cntr), m_miss);
`ifdef CACHE_EVICT_STATS_EN
        check({name, "_evict_cntr"}, 32'(evict_cntr), m_evict);
        check({name, "_wb_cntr"}, 32'(wb_cntr), m_wb);
`else
        check({name, "_evict_cntr"}, 32'(evict_cntr), 0);
        check({name, "_wb_cntr"}, 32'(wb_cntr), 0);
`endif
    endtask

    task automatic run_cmd(input logic [3:0] cmd, input logic [31:0] addr, input string name);
        int guard, lat, exp_lat;
        logic eh, got;
        logic [2:0] ew;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready_before"}, 32'(req_ready), 1);
        req_valid = 1'b1;
        req_cmd = cmd;
        req_addr = addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cmd = 4'($urandom);
        req_addr = $urandom;
        model_cmd(cmd, addr, eh, ew);
        exp_lat = (cmd == 4'd8) ? SETS + 1 : 2;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_ready_low"}, 32'(req_ready), 0);
        check({name, "_resp_hit"}, 32'(resp_hit), 32'(eh));
        check({name, "_resp_way"}, 32'(resp_way), 32'(ew));
        obs_hit = resp_hit;
        obs_way = resp_way;
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(resp_valid), 0);
        check({name, "_ready_after"}, 32'(req_ready), 1);
        check({name, "_hold_hit"}, 32'(resp_hit), 32'(eh));
        check_counters(name);
    endtask

    function automatic logic [3:0] rand_cmd();
        int r;
        logic [3:0] c;
        r = $urandom_range(0, 99);
        if (r < 35) c = 4'd0;
        else if (r < 60) c = 4'd1;
        else if (r < 75) c = 4'd2;
        else if (r < 90) c = 4'd3;
        else if (r < 92) c = 4'd8;
        else begin
            c = 4'($urandom_range(4, 15));
            if (c == 4'd8) c = 4'd9;
        end
        return c;
    endfunction

    initial begin
        int guard;
        logic saw_pulse;
        logic [31:0] a;
        model_reset();
        repeat (3) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_hit", 32'(resp_hit), 0);
        check("rst_resp_way", 32'(resp_way), 0);
        check_counters("rst");

        run_cmd(4'd0, 32'h0000_1000, "rd1000_miss");
        check("rd1000_miss_const", {obs_hit, obs_way}, 0);
        run_cmd(4'd0, 32'h0000_1000, "rd1000_hit");
        check("rd1000_hit_const", {obs_hit, obs_way}, 32'h8);

        // Reset while a read sits in LOOKUP: nothing from it may survive.
        req_valid = 1'b1; req_cmd = 4'd0; req_addr = 32'h0000_5000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rstb = 1'b1;
        model_reset();
        @(negedge clk);
        rstb = 1'b0;
        saw_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) saw_pulse = 1'b1;
        end
        check("midrst_no_pulse", 32'(saw_pulse), 0);
        check("midrst_ready", 32'(req_ready), 1);
        check_counters("midrst");

        for (int k = 0; k < 8; k++) begin
            run_cmd(4'd0, 32'(k) * 32'h1000, $sformatf("fill_set0_k%0d", k));
            check($sformatf("fill_set0_way_k%0d", k), 32'(obs_way), k);
        end
        run_cmd(4'd0, 32'h0000_8000, "set0_k8");
        check("set0_k8_victim0", {obs_hit, obs_way}, 0);

        run_cmd(4'd1, 32'h0000_2040, "wr2040");
        for (int t = 3; t <= 10; t++)
            run_cmd(4'd0, (32'(t) << 12) | 32'h40, $sformatf("set1_t%0d", t));
        check("set1_dirty_victim_way", 32'(obs_way), 0);

        run_cmd(4'd0, 32'h0000_3000, "rd3000");
        run_cmd(4'd3, 32'h0000_3000, "snoop3000");
        check("snoop3000_hit", 32'(obs_hit), 1);
        run_cmd(4'd0, 32'h0000_3000, "rd3000_again");
        check("rd3000_again_miss", 32'(obs_hit), 0);
        run_cmd(4'd3, 32'h0007_7000, "snoop_miss");
        run_cmd(4'd5, 32'h0000_1000, "noop5");
        check("noop5_const", {obs_hit, obs_way}, 0);

        run_cmd(4'd8, 32'h0000_0000, "clear");
        check("clear_hit_cntr_zero", 32'(hit_cntr), 0);
        run_cmd(4'd0, 32'h0000_1000, "post_clear_rd");
        check("post_clear_rd_miss", 32'(obs_hit), 0);

        for (int n = 0; n < 250; n++) begin
            a = ((32'($urandom_range(0, 11)) * 32'h1357) << 12)
              | (32'($urandom_range(0, 3)) << 6)
              | 32'($urandom_range(0, 63));
            run_cmd(rand_cmd(), a, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
